// File: rtl/ps_loop_stck_ctrl.sv
// ps_loop_stck_ctrl: nested hardware loop stack for the program sequencer.
// Optional PS_LP_ZERO_SKIP_EN: zero-count pushes skip the body instead of running it once.
module ps_loop_stck_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW = 16,
  parameter int CW = 16
) (
  input  logic          clk_fetch,
  input  logic          rst,
  input  logic          stallb,
  input  logic          ps_lp_push,
  input  logic [AW-1:0] ps_lp_saddr,
  input  logic [AW-1:0] ps_lp_laddr,
  input  logic [CW-1:0] ps_lp_cnt,
  input  logic          ps_lp_pop,
  input  logic          ps_lp_clr,
  input  logic [AW-1:0] ps_faddr,
  output logic          lp_ps_jmp,
  output logic [AW-1:0] lp_ps_jadd,
  output logic [CW-1:0] lp_ps_curlcntr,
  output logic [AW-1:0] lp_ps_laddr,
  output logic [4:0]    lp_ps_depth,
  output logic          lp_ps_empty,
  output logic          lp_ps_full,
  output logic          lp_ps_ovf,
  output logic          lp_ps_unf,
  output logic          lp_ps_done
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {EMPTY, ACTIVE, ERR} st_t;
  st_t st, st_nxt;
  logic [AW-1:0] sa [DEPTH];
  logic [AW-1:0] la [DEPTH];
  logic [CW-1:0] ca [DEPTH];
  logic [4:0] depth, d1, d_nxt;
  logic [IW-1:0] top_i, wi;
  logic [AW-1:0] t_s, t_l, skip_a;
  logic [CW-1:0] t_c, cin;
  logic end_hit, end_pop, go, xpop, unf_set, pop, zskip, psh, ovf_set, wr, dec;
  logic ovf, unf, done_q, skip_q;
  always_comb begin
    top_i = IW'(depth - 5'd1);
    t_s = (depth != 5'd0) ? sa[top_i] : '0;
    t_l = (depth != 5'd0) ? la[top_i] : '0;
    t_c = (depth != 5'd0) ? ca[top_i] : '0;
    end_hit = (st == ACTIVE) & stallb & (ps_faddr == t_l);
    end_pop = end_hit & (t_c <= CW'(1));
    go = stallb & (st != ERR) & ~ps_lp_clr;
    xpop = go & ps_lp_pop & ~end_pop & (depth != 5'd0);
    unf_set = go & ps_lp_pop & (depth == 5'd0);
    pop = end_pop | xpop;
    d1 = depth - {4'd0, pop};
`ifdef PS_LP_ZERO_SKIP_EN
    zskip = go & ps_lp_push & (ps_lp_cnt == '0);
    cin = ps_lp_cnt;
`else
    zskip = 1'b0;
    cin = (ps_lp_cnt == '0) ? CW'(1) : ps_lp_cnt;
`endif
    psh = go & ps_lp_push & ~zskip;
    ovf_set = psh & (d1 == 5'(DEPTH));
    wr = psh & ~ovf_set;
    wi = IW'(d1);
    dec = end_hit & ~end_pop & ~xpop;
    d_nxt = d1 + {4'd0, wr};
    st_nxt = (st == ERR) ? (ps_lp_clr ? EMPTY : ERR) :
             ovf_set ? ERR : (d_nxt == 5'd0) ? EMPTY : ACTIVE;
  end
  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) begin
      st <= EMPTY;
      depth <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      done_q <= 1'b0;
      skip_q <= 1'b0;
      skip_a <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sa[i] <= '0;
        la[i] <= '0;
        ca[i] <= '0;
      end
    end else if (stallb) begin
      st <= st_nxt;
      depth <= (st == ERR && ps_lp_clr) ? 5'd0 : d_nxt;
      if (wr) begin
        sa[wi] <= ps_lp_saddr;
        la[wi] <= ps_lp_laddr;
        ca[wi] <= cin;
      end
      if (dec) ca[top_i] <= t_c - CW'(1);
      ovf <= ps_lp_clr ? 1'b0 : (ovf | ovf_set);
      unf <= ps_lp_clr ? 1'b0 : (unf | unf_set);
      done_q <= end_pop | zskip;
      skip_q <= zskip;
      skip_a <= ps_lp_laddr + AW'(1);
    end
  end
  assign lp_ps_jmp = stallb & (st != ERR) & (skip_q | (end_hit & (t_c > CW'(1))));
  assign lp_ps_jadd = skip_q ? skip_a : t_s;
  assign lp_ps_curlcntr = t_c;
  assign lp_ps_laddr = t_l;
  assign lp_ps_depth = depth;
  assign lp_ps_empty = depth == 5'd0;
  assign lp_ps_full = depth == 5'(DEPTH);
  assign lp_ps_ovf = ovf;
  assign lp_ps_unf = unf;
  assign lp_ps_done = done_q & stallb;
endmodule

// File: tb/tb_ps_loop_stck_ctrl.sv
// tb_ps_loop_stck_ctrl: directed checks of the loop stack controller.
module tb_ps_loop_stck_ctrl;
  logic clk_fetch = 0, rst = 0, stallb = 1, ps_lp_push = 0, ps_lp_pop = 0, ps_lp_clr = 0;
  logic [15:0] ps_lp_saddr = 0, ps_lp_laddr = 0, ps_lp_cnt = 0, ps_faddr = 16'hffff;
  logic lp_ps_jmp, lp_ps_empty, lp_ps_full, lp_ps_ovf, lp_ps_unf, lp_ps_done;
  logic [15:0] lp_ps_jadd, lp_ps_curlcntr, lp_ps_laddr;
  logic [4:0] lp_ps_depth;
  int checks = 0, failures = 0, ndone = 0;
  logic last_jmp;
  logic [15:0] last_jadd;
  always #5 clk_fetch = ~clk_fetch;
  ps_loop_stck_ctrl dut (
    .clk_fetch(clk_fetch), .rst(rst), .stallb(stallb),
    .ps_lp_push(ps_lp_push), .ps_lp_saddr(ps_lp_saddr), .ps_lp_laddr(ps_lp_laddr),
    .ps_lp_cnt(ps_lp_cnt), .ps_lp_pop(ps_lp_pop), .ps_lp_clr(ps_lp_clr),
    .ps_faddr(ps_faddr), .lp_ps_jmp(lp_ps_jmp), .lp_ps_jadd(lp_ps_jadd),
    .lp_ps_curlcntr(lp_ps_curlcntr), .lp_ps_laddr(lp_ps_laddr), .lp_ps_depth(lp_ps_depth),
    .lp_ps_empty(lp_ps_empty), .lp_ps_full(lp_ps_full), .lp_ps_ovf(lp_ps_ovf),
    .lp_ps_unf(lp_ps_unf), .lp_ps_done(lp_ps_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_fetch);
    #1;
  endtask
  task automatic push(input logic [15:0] s, input logic [15:0] l, input logic [15:0] c);
    ps_lp_push = 1; ps_lp_saddr = s; ps_lp_laddr = l; ps_lp_cnt = c;
    step();
    ps_lp_push = 0;
  endtask
  task automatic fetch(input logic [15:0] a);
    ps_faddr = a;
    #2;
    last_jmp = lp_ps_jmp;
    last_jadd = lp_ps_jadd;
    step();
    if (lp_ps_done) ndone++;
    ps_faddr = 16'hffff;
  endtask
  initial begin
    #2;
    chk("rst_depth", lp_ps_depth, 0);
    chk("rst_empty", lp_ps_empty, 1);
    chk("rst_flags", {lp_ps_full, lp_ps_ovf, lp_ps_unf, lp_ps_done, lp_ps_jmp}, 0);
    chk("rst_top", {lp_ps_curlcntr, lp_ps_laddr}, 0);
    step();
    rst = 1;
    step();
    push(16'h10, 16'h14, 3);
    chk("t1_depth", lp_ps_depth, 1);
    chk("t1_cnt", lp_ps_curlcntr, 3);
    chk("t1_laddr", lp_ps_laddr, 16'h14);
    for (int p = 0; p < 3; p++) begin
      for (int a = 16'h10; a <= 16'h14; a++) begin
        fetch(16'(a));
        if (a == 16'h12) chk("t1_nojmp_mid", last_jmp, 0);
      end
      chk("t1_jmp", last_jmp, p < 2);
      if (p < 2) chk("t1_jadd", last_jadd, 16'h10);
      if (p < 2) chk("t1_cnt_dec", lp_ps_curlcntr, 2 - p);
    end
    chk("t1_done", lp_ps_done, 1);
    chk("t1_empty", lp_ps_empty, 1);
    step();
    chk("t1_done_pulse", lp_ps_done, 0);
    ndone = 0;
    push(16'h20, 16'h30, 2);
    for (int op = 0; op < 2; op++) begin
      fetch(16'h20);
      ps_lp_push = 1; ps_lp_saddr = 16'h22; ps_lp_laddr = 16'h25; ps_lp_cnt = 2;
      fetch(16'h21);
      ps_lp_push = 0;
      chk("t2_depth2", lp_ps_depth, 2);
      for (int ii = 0; ii < 2; ii++) begin
        for (int a = 16'h22; a <= 16'h25; a++) fetch(16'(a));
        chk("t2_inner_jmp", last_jmp, ii == 0);
      end
      chk("t2_depth1", lp_ps_depth, 1);
      for (int a = 16'h26; a <= 16'h30; a++) fetch(16'(a));
      chk("t2_outer_jmp", last_jmp, op == 0);
      if (op == 0) chk("t2_outer_jadd", last_jadd, 16'h20);
    end
    chk("t2_depth0", lp_ps_depth, 0);
    chk("t2_ndone", ndone, 3);
    for (int i = 0; i < 5; i++) begin
      push(16'(16'h100 + i * 16), 16'(16'h108 + i * 16), 2);
      if (i == 3) chk("t3_full", lp_ps_full, 1);
      if (i == 3) chk("t3_no_ovf", lp_ps_ovf, 0);
    end
    chk("t3_ovf", lp_ps_ovf, 1);
    chk("t3_full_err", lp_ps_full, 1);
    chk("t3_top", lp_ps_laddr, 16'h138);
    ps_faddr = 16'h138;
    #2;
    chk("t3_err_nojmp", lp_ps_jmp, 0);
    ps_faddr = 16'hffff;
    ps_lp_clr = 1;
    step();
    ps_lp_clr = 0;
    chk("t3_clr_empty", lp_ps_empty, 1);
    chk("t3_clr_ovf", lp_ps_ovf, 0);
    ps_lp_pop = 1;
    step();
    ps_lp_pop = 0;
    chk("t4_unf", lp_ps_unf, 1);
    chk("t4_unf_depth", lp_ps_depth, 0);
    ps_lp_clr = 1;
    step();
    ps_lp_clr = 0;
    chk("t4_unf_clr", lp_ps_unf, 0);
    push(16'h50, 16'h55, 1);
    ps_lp_push = 1; ps_lp_saddr = 16'h60; ps_lp_laddr = 16'h66; ps_lp_cnt = 5;
    fetch(16'h55);
    ps_lp_push = 0;
    chk("t4_pp_jmp", last_jmp, 0);
    chk("t4_pp_depth", lp_ps_depth, 1);
    chk("t4_pp_top", {lp_ps_laddr, lp_ps_curlcntr}, {16'h66, 16'd5});
    chk("t4_pp_done", lp_ps_done, 1);
    ps_lp_pop = 1;
    step();
    ps_lp_pop = 0;
    chk("t4_xpop", lp_ps_empty, 1);
    push(16'h70, 16'h72, 3);
    ps_faddr = 16'h72;
    stallb = 0;
    #2;
    chk("t5_stall_jmp", lp_ps_jmp, 0);
    step();
    chk("t5_stall_cnt", lp_ps_curlcntr, 3);
    stallb = 1;
    #2;
    chk("t5_rel_jmp", lp_ps_jmp, 1);
    step();
    chk("t5_rel_cnt", lp_ps_curlcntr, 2);
    ps_faddr = 16'hffff;
    ps_lp_pop = 1;
    step();
    ps_lp_pop = 0;
`ifdef PS_LP_ZERO_SKIP_EN
    push(16'h3e, 16'h40, 0);
    chk("t6_skip_jmp", lp_ps_jmp, 1);
    chk("t6_skip_jadd", lp_ps_jadd, 16'h41);
    chk("t6_skip_depth", lp_ps_depth, 0);
    chk("t6_skip_done", lp_ps_done, 1);
`else
    push(16'h40, 16'h42, 0);
    chk("t6_z_depth", lp_ps_depth, 1);
    chk("t6_z_cnt", lp_ps_curlcntr, 1);
    for (int a = 16'h40; a <= 16'h42; a++) fetch(16'(a));
    chk("t6_z_nojmp", last_jmp, 0);
    chk("t6_z_done", lp_ps_done, 1);
    chk("t6_z_empty", lp_ps_empty, 1);
`endif
    step();
    push(16'h80, 16'h84, 2);
    ps_faddr = 16'h84;
    #2;
    rst = 0;
    #1;
    chk("rst_mid_depth", lp_ps_depth, 0);
    chk("rst_mid_out", {lp_ps_done, lp_ps_jmp}, 0);
    step();
    rst = 1;
    ps_faddr = 16'hffff;
    step();
    chk("rst_mid_empty", lp_ps_empty, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
